dp_ram_be: RTL and testbench
============================

// Module: dp_ram_be
// PURPOSE
//  Parametrised successor dual-port RAM: two symmetric read/write ports on one clock, adding byte-write
//  enables, configurable read latency with rvalid, defined same-address collision semantics,
//  post-reset memory clear with busy flag, and a saturating collision counter.
//  Used as register-file / shared scratch memory between the two cores of proc_paralel.
// PARAMETERS
//  ADDR_WIDTH    8          address bits per port
//  DATA_WIDTH    32         word width; must be a multiple of 8
//  DEPTH         1<<ADDR_WIDTH  words implemented; DEPTH <= 2**ADDR_WIDTH
//  READ_LATENCY  1          0, 1 or 2 cycles from accepted read to rdata/rvalid
//  RDW_MODE      READ_FIRST  READ_FIRST | WRITE_FIRST (dp_ram_pkg::rdw_mode_e)
//  WR_PRIO       PRIO_A     port winning byte-lane write conflicts (dp_ram_pkg::prio_e)
//  CNT_WIDTH     16         collision counter width
// PORTS
//  clk              in   1           clock, all state on rising edge
//  rst              in   1           synchronous active-high reset
//  busy             out  1           1 while memory clear in progress; port requests ignored
//  a_en / b_en      in   1           port request
//  a_we / b_we      in   DATA_WIDTH/8  byte write enables (0 = pure read)
//  a_addr / b_addr  in   ADDR_WIDTH  word address
//  a_wdata / b_wdata in  DATA_WIDTH  write data
//  a_rdata / b_rdata out DATA_WIDTH  read data
//  a_rvalid / b_rvalid out 1         rdata valid strobe
//  collision        out  1           one-cycle pulse: same-address access with >=1 writer
//  collision_cnt    out  CNT_WIDTH   saturating count of collisions
// BEHAVIOUR
//  - Reset: FSM -> CLEAR, clr_addr=0, busy=1, rvalid=0, rdata=0, collision=0, collision_cnt=0.
//  - CLEAR: writes 0 to mem[clr_addr] each cycle, clr_addr++; after DEPTH-1 -> READY, busy=0 next cycle.
//    Clear takes exactly DEPTH cycles. rst asserted mid-clear restarts at address 0. rst in READY re-clears.
//  - Accept = en & ~busy. Every accepted request is a read of addr; bytes with we=1 also written.
//  - Address >= DEPTH: writes dropped, read returns 0, rvalid still asserted.
//  - READ_LATENCY=0: rdata combinational from mem, rvalid = accept, same cycle.
//    READ_LATENCY=1/2: rdata/rvalid registered, appear 1/2 cycles after accept; back-to-back fully pipelined.
//  - Read-during-write (same port or other port, same address, same cycle):
//    READ_FIRST -> reader gets pre-write word; WRITE_FIRST -> reader gets merged post-write word.
//    With READ_LATENCY=0, WRITE_FIRST reads are the combinational merge of wdata over mem.
//  - Both ports write same address: per byte lane, lane written by one port only -> that port's byte;
//    lane written by both -> WR_PRIO port's byte. Merged word is a single write.
//  - collision pulses the cycle after the accepted colliding pair; collision_cnt increments same time,
//    holds at 2**CNT_WIDTH-1. Two reads of the same address are not a collision.
//  - Requests during busy produce no rvalid and no writes; no queueing.
// STRUCTURE
//  - dp_ram_pkg: rdw_mode_e, prio_e, state_e {CLEAR, READY}, function byte_merge(old,new,be).
//  - Sub-module dp_ram_rd_pipe (#DATA_WIDTH, #READ_LATENCY): per-port rdata/rvalid delay line,
//    instantiated twice; zeroed by rst.
//  - Storage: one array, single always_ff write process with merged lane-by-lane write enables.
// TESTING
//  1 rst for 1 cycle, DEPTH=16 -> busy=1 for exactly 16 cycles; then read all addrs -> 0, rvalid after READ_LATENCY.
//  2 A writes 0xDEADBEEF @3 we=4'hF, then A we=4'b0010 data 0x0000_5500 -> B read @3 returns 0xDEAD55EF.
//  3 Same cycle A we=F 0x11111111, B we=4'b0011 0x22222222 @5, WR_PRIO=PRIO_A -> mem[5]=0x11111111; PRIO_B -> 0x11112222; collision=1 next cycle, cnt=1.
//  4 mem[7]=0xAAAA_AAAA; A writes 0x5555_5555 @7 while B reads @7 -> READ_FIRST: B=0xAAAAAAAA; WRITE_FIRST: B=0x55555555.
//  5 rst asserted at clear cycle 10, then during READY with traffic -> clear restarts at 0, busy 16 cycles, requests during busy give no rvalid, cnt=0.
//  6 CNT_WIDTH=2, 5 colliding cycles -> collision_cnt sticks at 3; A/B both read @9 -> no collision pulse.

Source files
------------

// File: rtl/dp_ram_pkg.sv
// Shared types and the byte-lane merge helper for the byte-enable dual-port RAM.
package dp_ram_pkg;

    typedef enum logic {READ_FIRST, WRITE_FIRST} rdw_mode_e;
    typedef enum logic {PRIO_A, PRIO_B} prio_e;
    typedef enum logic {CLEAR, READY} state_e;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int unsigned MAX_DATA_WIDTH = 256;
    localparam int unsigned MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

    // Replace every byte of old_word whose enable bit is set with the byte of new_word.
    function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_BE_WIDTH-1:0]   be
    );
        logic [MAX_DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < MAX_BE_WIDTH; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dp_ram_rd_pipe.sv
// Per-port read data / valid delay line; latency 0 is a straight wire.
module dp_ram_rd_pipe #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    if (READ_LATENCY == 0) begin : g_comb
        logic w_unused;
        assign w_unused = i_clk ^ i_rst;
        assign o_valid  = i_valid;
        assign o_data   = i_data;
    end else begin : g_reg
        logic [READ_LATENCY-1:0] r_valid;
        logic [DATA_WIDTH-1:0]   r_data [READ_LATENCY];

        // Shift valid and data one stage per cycle; reset empties the pipe.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_valid <= '0;
                for (int i = 0; i < READ_LATENCY; i++) begin
                    r_data[i] <= '0;
                end
            end else begin
                r_valid[0] <= i_valid;
                r_data[0]  <= i_data;
                for (int i = 1; i < READ_LATENCY; i++) begin
                    r_valid[i] <= r_valid[i-1];
                    r_data[i]  <= r_data[i-1];
                end
            end
        end

        assign o_valid = r_valid[READ_LATENCY-1];
        assign o_data  = r_data[READ_LATENCY-1];
    end

endmodule

// File: rtl/dp_ram_be.sv
// Dual-port RAM with byte enables, configurable read latency, defined collision behaviour,
// post-reset memory clear and a saturating collision counter.
module dp_ram_be
    import dp_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 1 << ADDR_WIDTH,
    parameter int unsigned READ_LATENCY = 1,
    parameter rdw_mode_e   RDW_MODE     = READ_FIRST,
    parameter prio_e       WR_PRIO      = PRIO_A,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    output logic                    o_busy,
    input  logic                    i_a_en,
    input  logic [DATA_WIDTH/8-1:0] i_a_we,
    input  logic [ADDR_WIDTH-1:0]   i_a_addr,
    input  logic [DATA_WIDTH-1:0]   i_a_wdata,
    output logic [DATA_WIDTH-1:0]   o_a_rdata,
    output logic                    o_a_rvalid,
    input  logic                    i_b_en,
    input  logic [DATA_WIDTH/8-1:0] i_b_we,
    input  logic [ADDR_WIDTH-1:0]   i_b_addr,
    input  logic [DATA_WIDTH-1:0]   i_b_wdata,
    output logic [DATA_WIDTH-1:0]   o_b_rdata,
    output logic                    o_b_rvalid,
    output logic                    o_collision,
    output logic [CNT_WIDTH-1:0]    o_collision_cnt
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_CMP = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_ADDR = IDX_W'(DEPTH - 1);

    function automatic logic [DATA_WIDTH-1:0] merge(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [BE_W-1:0]       be
    );
        return DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(old_word), MAX_DATA_WIDTH'(new_word),
                                      MAX_BE_WIDTH'(be)));
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    state_e                r_state;
    logic [IDX_W-1:0]      r_clr_addr;
    logic                  r_busy;
    logic                  r_collision;
    logic [CNT_WIDTH-1:0]  r_cnt;

    logic                  w_acc_a, w_acc_b, w_inr_a, w_inr_b, w_same, w_coll;
    logic [IDX_W-1:0]      w_idx_a, w_idx_b;
    logic [BE_W-1:0]       w_wa, w_wb, w_a_at_b, w_b_at_a;
    logic [DATA_WIDTH-1:0] w_old_a, w_old_b, w_post_a, w_post_b, w_raw_a, w_raw_b;

    // Reset blocks acceptance too, so a request in the reset cycle never lands.
    assign w_acc_a  = i_a_en & ~r_busy & ~i_rst;
    assign w_acc_b  = i_b_en & ~r_busy & ~i_rst;
    assign w_inr_a  = ({1'b0, i_a_addr} < DEPTH_CMP);
    assign w_inr_b  = ({1'b0, i_b_addr} < DEPTH_CMP);
    assign w_idx_a  = i_a_addr[IDX_W-1:0];
    assign w_idx_b  = i_b_addr[IDX_W-1:0];
    assign w_same   = (i_a_addr == i_b_addr);
    assign w_wa     = (w_acc_a && w_inr_a) ? i_a_we : '0;
    assign w_wb     = (w_acc_b && w_inr_b) ? i_b_we : '0;
    assign w_a_at_b = w_same ? w_wa : '0;
    assign w_b_at_a = w_same ? w_wb : '0;
    assign w_coll   = w_acc_a & w_acc_b & w_same & ((|i_a_we) | (|i_b_we));

    // Pre-write words, post-write merged words (losing port applied first) and per-port read data.
    always_comb begin
        w_old_a = w_inr_a ? r_mem[w_idx_a] : '0;
        w_old_b = w_inr_b ? r_mem[w_idx_b] : '0;
        if (WR_PRIO == PRIO_A) begin
            w_post_a = merge(merge(w_old_a, i_b_wdata, w_b_at_a), i_a_wdata, w_wa);
            w_post_b = merge(merge(w_old_b, i_b_wdata, w_wb), i_a_wdata, w_a_at_b);
        end else begin
            w_post_a = merge(merge(w_old_a, i_a_wdata, w_wa), i_b_wdata, w_b_at_a);
            w_post_b = merge(merge(w_old_b, i_a_wdata, w_a_at_b), i_b_wdata, w_wb);
        end
        w_raw_a = '0;
        w_raw_b = '0;
        if (w_acc_a) begin
            w_raw_a = (RDW_MODE == WRITE_FIRST) ? w_post_a : w_old_a;
        end
        if (w_acc_b) begin
            w_raw_b = (RDW_MODE == WRITE_FIRST) ? w_post_b : w_old_b;
        end
    end

    // Storage: clear sweep while busy, otherwise lane-by-lane writes of the merged words.
    always_ff @(posedge i_clk) begin
        if (r_busy) begin
            r_mem[r_clr_addr] <= '0;
        end else begin
            for (int i = 0; i < BE_W; i++) begin
                if (w_wa[i]) begin
                    r_mem[w_idx_a][8*i +: 8] <= w_post_a[8*i +: 8];
                end
                // A shared lane is already covered by port A's write of the same merged byte.
                if (w_wb[i] && !w_a_at_b[i]) begin
                    r_mem[w_idx_b][8*i +: 8] <= w_post_b[8*i +: 8];
                end
            end
        end
    end

    // Clear FSM: sweep every address once after reset, then serve requests.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= CLEAR;
            r_clr_addr <= '0;
            r_busy     <= 1'b1;
        end else if (r_state == CLEAR) begin
            r_clr_addr <= r_clr_addr + 1'b1;
            if (r_clr_addr == LAST_ADDR) begin
                r_state <= READY;
                r_busy  <= 1'b0;
            end
        end
    end

    // Collision pulse and saturating counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_collision <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_collision <= w_coll;
            if (w_coll && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_busy          = r_busy;
    assign o_collision     = r_collision;
    assign o_collision_cnt = r_cnt;

    dp_ram_rd_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_pipe_a (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_valid(w_acc_a),
        .i_data (w_raw_a),
        .o_valid(o_a_rvalid),
        .o_data (o_a_rdata)
    );

    dp_ram_rd_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_pipe_b (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_valid(w_acc_b),
        .i_data (w_raw_b),
        .o_valid(o_b_rvalid),
        .o_data (o_b_rdata)
    );

endmodule

// File: tb/tb_dp_ram_be.sv
// Bench for dp_ram_be: three configurations share one stimulus stream and one reference model.
//   inst0: latency 1, READ_FIRST,  PRIO_A, 2-bit counter
//   inst1: latency 2, WRITE_FIRST, PRIO_B, 16-bit counter
//   inst2: latency 0, WRITE_FIRST, PRIO_A, 16-bit counter
module tb_dp_ram_be;
    import dp_ram_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, a_en, b_en;
    logic [3:0]  a_we, b_we;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;

    logic        busy [3];
    logic [31:0] ard [3];
    logic [31:0] brd [3];
    logic        arv [3];
    logic        brv [3];
    logic        coll [3];
    logic [1:0]  cnt0;
    logic [15:0] cnt1, cnt2;

    dp_ram_be #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .DEPTH(16), .READ_LATENCY(1),
                .RDW_MODE(READ_FIRST), .WR_PRIO(PRIO_A), .CNT_WIDTH(2)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .o_busy(busy[0]),
        .i_a_en(a_en), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
        .o_a_rdata(ard[0]), .o_a_rvalid(arv[0]),
        .i_b_en(b_en), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
        .o_b_rdata(brd[0]), .o_b_rvalid(brv[0]),
        .o_collision(coll[0]), .o_collision_cnt(cnt0));

    dp_ram_be #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .DEPTH(16), .READ_LATENCY(2),
                .RDW_MODE(WRITE_FIRST), .WR_PRIO(PRIO_B), .CNT_WIDTH(16)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .o_busy(busy[1]),
        .i_a_en(a_en), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
        .o_a_rdata(ard[1]), .o_a_rvalid(arv[1]),
        .i_b_en(b_en), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
        .o_b_rdata(brd[1]), .o_b_rvalid(brv[1]),
        .o_collision(coll[1]), .o_collision_cnt(cnt1));

    dp_ram_be #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .DEPTH(16), .READ_LATENCY(0),
                .RDW_MODE(WRITE_FIRST), .WR_PRIO(PRIO_A), .CNT_WIDTH(16)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .o_busy(busy[2]),
        .i_a_en(a_en), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
        .o_a_rdata(ard[2]), .o_a_rvalid(arv[2]),
        .i_b_en(b_en), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
        .o_b_rdata(brd[2]), .o_b_rvalid(brv[2]),
        .o_collision(coll[2]), .o_collision_cnt(cnt2));

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 0;
    endfunction
    function automatic bit wf_of(input int k);
        return (k != 0);
    endfunction
    function automatic bit prio_b_of(input int k);
        return (k == 1);
    endfunction
    function automatic int cmax_of(input int k);
        return (k == 0) ? 3 : 65535;
    endfunction

    // Reference model state.
    logic [31:0] m_mem [3][16];
    bit          m_busy [3];
    int          m_clr [3];
    bit          m_coll [3];
    int          m_cnt [3];
    bit          hv_a [3][4];
    bit          hv_b [3][4];
    logic [31:0] hd_a [3][4];
    logic [31:0] hd_b [3][4];
    logic [31:0] lastb [3];
    int          cyc = 4;
    bit          chk_on = 0;
    int          busy_seen = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called once per cycle just before the rising edge: compare, then advance the model.
    task automatic step();
        logic [31:0] nm [16];
        logic [31:0] ra, rb;
        bit          acc_a, acc_b, inr_a, inr_b, col;
        int          h, hp, port;
        h = cyc % 4;
        for (int k = 0; k < 3; k++) begin
            acc_a = a_en && !m_busy[k] && !rst;
            acc_b = b_en && !m_busy[k] && !rst;
            inr_a = (a_addr < 5'd16);
            inr_b = (b_addr < 5'd16);
            for (int w = 0; w < 16; w++) nm[w] = m_mem[k][w];
            // Apply the losing port's bytes first so the winner overwrites shared lanes.
            for (int p = 0; p < 2; p++) begin
                port = prio_b_of(k) ? p : 1 - p;
                for (int l = 0; l < 4; l++) begin
                    if (port == 0 && acc_a && inr_a && a_we[l])
                        nm[a_addr[3:0]][8*l +: 8] = a_wdata[8*l +: 8];
                    if (port == 1 && acc_b && inr_b && b_we[l])
                        nm[b_addr[3:0]][8*l +: 8] = b_wdata[8*l +: 8];
                end
            end
            ra = 32'h0;
            rb = 32'h0;
            if (acc_a && inr_a) ra = wf_of(k) ? nm[a_addr[3:0]] : m_mem[k][a_addr[3:0]];
            if (acc_b && inr_b) rb = wf_of(k) ? nm[b_addr[3:0]] : m_mem[k][b_addr[3:0]];
            hv_a[k][h] = acc_a;
            hd_a[k][h] = ra;
            hv_b[k][h] = acc_b;
            hd_b[k][h] = rb;
            col = acc_a && acc_b && (a_addr == b_addr) && (a_we != 4'h0 || b_we != 4'h0);

            if (chk_on) begin
                hp = (cyc - lat_of(k) + 4) % 4;
                check($sformatf("busy%0d", k), 32'(busy[k]), 32'(m_busy[k]));
                check($sformatf("a_rvalid%0d", k), 32'(arv[k]), 32'(hv_a[k][hp]));
                check($sformatf("b_rvalid%0d", k), 32'(brv[k]), 32'(hv_b[k][hp]));
                check($sformatf("a_rdata%0d", k), ard[k], hd_a[k][hp]);
                check($sformatf("b_rdata%0d", k), brd[k], hd_b[k][hp]);
                check($sformatf("collision%0d", k), 32'(coll[k]), 32'(m_coll[k]));
                check($sformatf("cnt%0d", k),
                      (k == 0) ? 32'(cnt0) : (k == 1) ? 32'(cnt1) : 32'(cnt2),
                      32'(m_cnt[k]));
                if (brv[k] === 1'b1) lastb[k] = brd[k];
                if (k == 0 && busy[0] === 1'b1) busy_seen++;
            end

            if (rst) begin
                m_busy[k] = 1;
                m_clr[k]  = 0;
                m_coll[k] = 0;
                m_cnt[k]  = 0;
                hv_a[k][(h + 3) % 4] = 0;
                hv_b[k][(h + 3) % 4] = 0;
                hd_a[k][(h + 3) % 4] = 32'h0;
                hd_b[k][(h + 3) % 4] = 32'h0;
            end else begin
                if (m_busy[k]) begin
                    m_mem[k][m_clr[k]] = 32'h0;
                    m_clr[k]++;
                    if (m_clr[k] == 16) m_busy[k] = 0;
                end else begin
                    for (int w = 0; w < 16; w++) m_mem[k][w] = nm[w];
                end
                m_coll[k] = col;
                if (col && m_cnt[k] < cmax_of(k)) m_cnt[k]++;
            end
        end
        if (rst) chk_on = 1;
        cyc++;
    endtask

    task automatic cyc_step();
        #4;
        step();
        @(negedge clk);
    endtask

    task automatic drive(input bit ae, input logic [3:0] awe, input logic [4:0] aad,
                         input logic [31:0] awd, input bit be, input logic [3:0] bwe,
                         input logic [4:0] bad, input logic [31:0] bwd);
        a_en = ae; a_we = awe; a_addr = aad; a_wdata = awd;
        b_en = be; b_we = bwe; b_addr = bad; b_wdata = bwd;
        cyc_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 4'h0, 5'd0, 32'h0, 0, 4'h0, 5'd0, 32'h0);
    endtask

    task automatic rand_cycle();
        logic [4:0] aa;
        aa = 5'($urandom_range(0, 19));
        drive($urandom_range(0, 3) != 0, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0,
              aa, $urandom,
              $urandom_range(0, 3) != 0, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0,
              ($urandom_range(0, 3) == 0) ? aa : 5'($urandom_range(0, 19)), $urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc_step();
        rst = 1'b0;
        busy_seen = 0;
    endtask

    typedef struct {
        bit          ae;
        logic [3:0]  awe;
        logic [4:0]  aad;
        logic [31:0] awd;
        bit          be;
        logic [3:0]  bwe;
        logic [4:0]  bad;
        logic [31:0] bwd;
        bit          chk;
        logic [31:0] exp [3];
    } vec_t;

    function automatic vec_t mk(input bit ae, input logic [3:0] awe, input logic [4:0] aad,
                                input logic [31:0] awd, input bit be, input logic [3:0] bwe,
                                input logic [4:0] bad, input logic [31:0] bwd, input bit chk,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2);
        vec_t v;
        v.ae = ae; v.awe = awe; v.aad = aad; v.awd = awd;
        v.be = be; v.bwe = bwe; v.bad = bad; v.bwd = bwd;
        v.chk = chk; v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2;
        return v;
    endfunction

    vec_t vt [10];

    initial begin
        vt[0] = mk(1, 4'hF, 5'd3, 32'hDEADBEEF, 0, 4'h0, 5'd0, 32'h0, 0, 0, 0, 0);
        vt[1] = mk(1, 4'h2, 5'd3, 32'h00005500, 0, 4'h0, 5'd0, 32'h0, 0, 0, 0, 0);
        vt[2] = mk(0, 4'h0, 5'd0, 32'h0, 1, 4'h0, 5'd3, 32'h0, 1,
                   32'hDEAD55EF, 32'hDEAD55EF, 32'hDEAD55EF);
        vt[3] = mk(1, 4'hF, 5'd5, 32'h11111111, 1, 4'h3, 5'd5, 32'h22222222, 1,
                   32'h00000000, 32'h11112222, 32'h11111111);
        vt[4] = mk(0, 4'h0, 5'd0, 32'h0, 1, 4'h0, 5'd5, 32'h0, 1,
                   32'h11111111, 32'h11112222, 32'h11111111);
        vt[5] = mk(1, 4'hF, 5'd7, 32'hAAAAAAAA, 0, 4'h0, 5'd0, 32'h0, 0, 0, 0, 0);
        vt[6] = mk(1, 4'hF, 5'd7, 32'h55555555, 1, 4'h0, 5'd7, 32'h0, 1,
                   32'hAAAAAAAA, 32'h55555555, 32'h55555555);
        vt[7] = mk(0, 4'h0, 5'd0, 32'h0, 1, 4'h0, 5'd7, 32'h0, 1,
                   32'h55555555, 32'h55555555, 32'h55555555);
        vt[8] = mk(0, 4'h0, 5'd0, 32'h0, 1, 4'hF, 5'd20, 32'hFFFFFFFF, 1, 0, 0, 0);
        vt[9] = mk(0, 4'h0, 5'd0, 32'h0, 1, 4'h0, 5'd20, 32'h0, 1, 0, 0, 0);

        rst = 1'b1;
        a_en = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_en = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        @(negedge clk);

        // Reset, clear duration, all addresses read back as zero.
        do_reset();
        idle(20);
        check("busy_cycles_after_reset", 32'(busy_seen), 32'd16);
        for (int i = 0; i < 16; i++) drive(1, 4'h0, 5'(15 - i), 32'h0, 1, 4'h0, 5'(i), 32'h0);
        idle(3);

        // Directed vectors: byte writes, write-write and read-during-write, out of range.
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 3; k++) lastb[k] = 32'hBAD0BAD0;
            drive(vt[i].ae, vt[i].awe, vt[i].aad, vt[i].awd,
                  vt[i].be, vt[i].bwe, vt[i].bad, vt[i].bwd);
            idle(3);
            if (vt[i].chk) begin
                for (int k = 0; k < 3; k++)
                    check($sformatf("vec%0d_b_rdata%0d", i, k), lastb[k], vt[i].exp[k]);
            end
        end

        // Counter saturation, then a read/read pair that must not pulse.
        do_reset();
        idle(17);
        for (int i = 0; i < 5; i++)
            drive(1, 4'hF, 5'd2, 32'(i), 1, 4'hF, 5'd2, 32'(i + 100));
        drive(1, 4'h0, 5'd9, 32'h0, 1, 4'h0, 5'd9, 32'h0);
        check("cnt_saturated_w2", 32'(cnt0), 32'd3);
        check("cnt_unsaturated_w16", 32'(cnt1), 32'd5);
        idle(1);
        check("no_collision_read_read", 32'(coll[0]), 32'd0);

        // Reset mid-clear with traffic, then reset during READY with traffic.
        do_reset();
        for (int i = 0; i < 10; i++) rand_cycle();
        do_reset();
        for (int i = 0; i < 20; i++) rand_cycle();
        check("busy_cycles_restart", 32'(busy_seen), 32'd16);
        for (int i = 0; i < 60; i++) rand_cycle();
        a_en = 1; b_en = 1; a_addr = 5'd4; b_addr = 5'd4; a_we = 4'hF; b_we = 4'hF;
        do_reset();
        check("cnt_cleared_by_reset", 32'(cnt1), 32'd0);
        for (int i = 0; i < 20; i++) rand_cycle();
        check("busy_cycles_reclear", 32'(busy_seen), 32'd16);

        // Long random run with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else rand_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
